// File: rtl/synth_buffer_writer.sv
// rtl/synth_buffer_writer.sv - oscillator sample generator writing stereo words into a BRAM ring
//
// Purpose: phase-accumulator oscillator (saw/square/triangle/silence) scaled by an
// unsigned amplitude; each sample is written as {L,R} into a BRAM ring buffer that a
// downstream DMA stage drains. The consumer's read pointer provides flow control so the
// ring never overruns (at most DEPTH-1 words held).
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            generate/write while ring space exists
//   phase_rst         synchronous pulse clearing the phase accumulator
//   phase_inc         phase increment applied after each written word
//   wave_sel          0 saw, 1 square, 2 triangle, 3 silence
//   amplitude         unsigned gain, 16'hFFFF ~ unity
//   rd_ptr            consumer's next word index to read
//   BRAM_*            BRAM write port (clk/rst forwarded, en/we/addr/din registered)
//   wr_ptr            next word index to write
//   full, level       combinational ring occupancy status
module synth_buffer_writer #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              phase_rst,
    input  logic [31:0]       phase_inc,
    input  logic [1:0]        wave_sel,
    input  logic [15:0]       amplitude,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [31:0]       BRAM_addr,
    output logic              BRAM_clk,
    output logic [31:0]       BRAM_din,
    output logic              BRAM_en,
    output logic              BRAM_rst,
    output logic [3:0]        BRAM_we,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              full,
    output logic [ADDR_W-1:0] level
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       phase_q;
    logic [31:0]       inc_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [31:0]       addr_q;
    logic [31:0]       din_q;
    logic              en_q;
    logic [3:0]        we_q;

    logic [ADDR_W-1:0] wr_ptr_d;
    logic [31:0]       addr_d;
    logic [15:0]       p;
    logic [14:0]       tri_t;
    logic signed [15:0] wave_d;
    logic signed [32:0] wave_x;
    logic signed [32:0] amp_x;
    logic signed [32:0] prod;
    logic [15:0]       sample_d;

    // Ring pointer arithmetic wraps naturally at ADDR_W bits.
    assign wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    assign addr_d   = BASE_ADDR + 32'({wr_ptr_d, 2'b00});
    assign full     = (wr_ptr_d == rd_ptr);
    assign level    = wr_ptr_q - rd_ptr;

    always_comb begin
        p      = phase_q[31:16];
        tri_t  = p[15] ? ~p[14:0] : p[14:0];
        wave_d = '0;
        case (wave_sel)
            2'd0:    wave_d = {~p[15], p[14:0]};
            2'd1:    wave_d = p[15] ? 16'sh8000 : 16'sh7FFF;
            2'd2:    wave_d = {tri_t, 1'b0} - 16'h8000;
            default: wave_d = '0;
        endcase
        // Both operands widened to 33 bits; |w*amp| < 2^31 so the product never overflows.
        wave_x   = 33'(wave_d);
        amp_x    = {17'b0, amplitude};
        prod     = wave_x * amp_x;
        sample_d = prod[31:16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            inc_q    <= '0;
            wr_ptr_q <= '0;
            addr_q   <= BASE_ADDR;
            din_q    <= '0;
            en_q     <= 1'b0;
            we_q     <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && !full) begin
                        state_q <= S_GEN;
                    end
                end
                S_GEN: begin
                    // Sample word and the increment it advances by are captured together,
                    // so config changes only affect the following word.
                    din_q   <= {sample_d, sample_d};
                    inc_q   <= phase_inc;
                    en_q    <= 1'b1;
                    we_q    <= 4'hF;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    en_q     <= 1'b0;
                    we_q     <= 4'h0;
                    wr_ptr_q <= wr_ptr_d;
                    addr_q   <= addr_d;
                    phase_q  <= phase_q + inc_q;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Placed after the case so it overrides the WRITE-state phase advance.
            if (phase_rst) begin
                phase_q <= '0;
            end
        end
    end

    assign BRAM_clk  = clk;
    assign BRAM_rst  = rst;
    assign BRAM_addr = addr_q;
    assign BRAM_din  = din_q;
    assign BRAM_en   = en_q;
    assign BRAM_we   = we_q;
    assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_synth_buffer_writer.sv
// tb/tb_synth_buffer_writer.sv - scoreboard bench for synth_buffer_writer
module tb_synth_buffer_writer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    bit                clk_run = 1'b0;
    logic              rst;
    logic              enable;
    logic              phase_rst;
    logic [31:0]       phase_inc;
    logic [1:0]        wave_sel;
    logic [15:0]       amplitude;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       BRAM_addr;
    logic              BRAM_clk;
    logic [31:0]       BRAM_din;
    logic              BRAM_en;
    logic              BRAM_rst;
    logic [3:0]        BRAM_we;
    logic [ADDR_W-1:0] wr_ptr;
    logic              full;
    logic [ADDR_W-1:0] level;

    synth_buffer_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .phase_rst (phase_rst),
        .phase_inc (phase_inc),
        .wave_sel  (wave_sel),
        .amplitude (amplitude),
        .rd_ptr    (rd_ptr),
        .BRAM_addr (BRAM_addr),
        .BRAM_clk  (BRAM_clk),
        .BRAM_din  (BRAM_din),
        .BRAM_en   (BRAM_en),
        .BRAM_rst  (BRAM_rst),
        .BRAM_we   (BRAM_we),
        .wr_ptr    (wr_ptr),
        .full      (full),
        .level     (level)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int writes_seen = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_din[$];

    logic [31:0] m_phase = '0;
    int          m_wr    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] ph, input logic [1:0] ws,
                                             input logic [15:0] amp);
        int p;
        int t;
        int w;
        longint prod;
        logic [15:0] s;
        p = int'(ph[31:16]);
        t = 0;
        case (ws)
            2'd0: w = p - 32768;
            2'd1: w = (p >= 32768) ? -32768 : 32767;
            2'd2: begin
                t = (p >= 32768) ? (32767 - (p - 32768)) : p;
                w = 2 * t - 32768;
            end
            default: w = 0;
        endcase
        prod = longint'(w) * longint'(amp);
        s = 16'(prod >>> 16);
        return {s, s};
    endfunction

    // Scoreboard consumer: every BRAM write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && BRAM_en) begin
            writes_seen++;
            if (q_addr.size() == 0) begin
                chk("unexpected_write_qsize", 32'(q_addr.size()), 32'd1);
            end else begin
                chk("addr", BRAM_addr, q_addr.pop_front());
                chk("din", BRAM_din, q_din.pop_front());
                chk("we", 32'(BRAM_we), 32'hF);
            end
        end
    end

    task automatic set_cfg(input logic [1:0] ws, input logic [15:0] amp, input logic [31:0] inc);
        wave_sel  = ws;
        amplitude = amp;
        phase_inc = inc;
    endtask

    task automatic push_word();
        q_addr.push_back(32'(m_wr) * 32'd4);
        q_din.push_back(exp_word(m_phase, wave_sel, amplitude));
        m_phase = m_phase + phase_inc;
        m_wr    = (m_wr + 1) % DEPTH;
    endtask

    task automatic pulse_phase_rst();
        @(negedge clk);
        phase_rst = 1'b1;
        @(negedge clk);
        phase_rst = 1'b0;
        m_phase = '0;
    endtask

    task automatic wait_drain(input int limit);
        int c;
        c = 0;
        while (q_addr.size() != 0 && c < limit) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("drain_left", 32'(q_addr.size()), 32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int w0;

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        phase_rst = 1'b0;
        rd_ptr = '0;
        set_cfg(2'd0, 16'hFFFF, 32'h0100_0000);
        #1 rst = 1'b1;
        #1;
        chk("rst_addr", BRAM_addr, 32'h0);
        chk("rst_din", BRAM_din, 32'h0);
        chk("rst_en", 32'(BRAM_en), 32'd0);
        chk("rst_we", 32'(BRAM_we), 32'd0);
        chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_bram_rst", 32'(BRAM_rst), 32'd1);

        clk_run = 1'b1;
        settle(3);
        rst = 1'b0;
        settle(100);
        chk("disabled_writes", 32'(writes_seen), 32'd0);

        // Fill the ring from empty with a saw: exactly DEPTH-1 words.
        for (int i = 0; i < DEPTH - 1; i++) push_word();
        enable = 1'b1;
        wait_drain(3 * DEPTH + 100);
        settle(10);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd1023);
        chk("fill_wr_ptr", 32'(wr_ptr), 32'd1023);

        // Consumer frees 10 words; writes wrap through the end of the ring.
        for (int i = 0; i < 10; i++) push_word();
        rd_ptr = 10'd10;
        wait_drain(100);
        settle(10);
        chk("wrap_wr_ptr", 32'(wr_ptr), 32'd9);
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_level", 32'(level), 32'd1023);

        // Half-amplitude square toggling every word.
        set_cfg(2'd1, 16'h8000, 32'h8000_0000);
        pulse_phase_rst();
        for (int i = 0; i < 6; i++) push_word();
        rd_ptr = rd_ptr + 10'd6;
        wait_drain(60);
        settle(10);
        chk("sq_full", 32'(full), 32'd1);

        // Enable drops while in GEN: that word still lands, nothing more follows.
        enable = 1'b0;
        rd_ptr = rd_ptr + 10'd5;
        set_cfg(2'd0, 16'hFFFF, 32'h0100_0000);
        pulse_phase_rst();
        push_word();
        w0 = writes_seen;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_drain(20);
        settle(20);
        chk("gen_drop_writes", 32'(writes_seen - w0), 32'd1);

        // After a phase reset the next saw word restarts at full negative.
        pulse_phase_rst();
        push_word();
        @(negedge clk);
        enable = 1'b1;
        wait_drain(20);
        enable = 1'b0;
        settle(10);

        // Silence on the remaining three slots: pointer advances, data is zero.
        set_cfg(2'd3, 16'hFFFF, 32'h0100_0000);
        for (int i = 0; i < 3; i++) push_word();
        enable = 1'b1;
        wait_drain(40);
        settle(10);
        chk("sil_wr_ptr", 32'(wr_ptr), 32'(m_wr));
        chk("sil_full", 32'(full), 32'd1);

        // Triangle at phase zero.
        set_cfg(2'd2, 16'hFFFF, 32'h0100_0000);
        pulse_phase_rst();
        push_word();
        rd_ptr = rd_ptr + 10'd1;
        wait_drain(20);
        settle(10);
        chk("tri_full", 32'(full), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
